config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Serial configuration-chain driver that sits directly upstream of the IO/logic tile configuration chain.
- Accepts configuration words from a host or bitstream source over a valid/ready interface.
- Clears the chain, then serializes the words LSB-first onto the chain input with the chain enable asserted.
- Checks the chain's tail output for continuity during load and reports done/error.

Parameters:
- WORD_WIDTH, 8, width of each incoming configuration word.
- CHAIN_LENGTH, 1024, total number of flops in the configuration chain (bits to shift); must be >= 1.
- CLEAR_CYCLES, 2, number of cycles cfg_nreset is held low before shifting; must be >= 1.

Ports:
- clock  input  1  single clock shared with the fabric configuration chain.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a configuration load; ignored while busy.
- word_data  input  WORD_WIDTH  configuration word; bit 0 is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- cfg_serial_out  output  1  drives the chain head's config_in.
- cfg_enable  output  1  drives the chain's config_enable; chain shifts one bit on each clock edge while high.
- cfg_nreset  output  1  drives the chain's config_nreset (active-low chain clear).
- cfg_serial_return  input  1  chain tail's config_out.
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  high in DONE state.
- error  output  1  sticky continuity error for the current or last load.

Behaviour:
- Reset (async, active-high) sets every register immediately; state=IDLE.
- Output values in reset: word_ready=0, cfg_serial_out=0, cfg_enable=0, cfg_nreset=1, busy=0, done=0, error=0.
- Derived constants:
  - NUM_WORDS = ceil(CHAIN_LENGTH/WORD_WIDTH).
  - Bit counter width = clog2(CHAIN_LENGTH+1).
  - Clear counter width = clog2(CLEAR_CYCLES+1).
- States: IDLE, CLEAR, LOAD, SHIFT, DONE.
- IDLE:
  - All outputs at reset values except done/error, which hold.
  - start=1 -> CLEAR; clears done and error, zeroes the bit counter, loads the clear counter.
- CLEAR:
  - cfg_nreset=0 for exactly CLEAR_CYCLES cycles, then -> LOAD.
  - cfg_enable=0 throughout.
- LOAD:
  - word_ready=1, cfg_enable=0.
  - On word_valid & word_ready: capture word_data into the shift register; per-word count = min(WORD_WIDTH, CHAIN_LENGTH - bits_shifted); -> SHIFT.
  - With no valid word, stay in LOAD indefinitely; the chain holds.
- SHIFT:
  - cfg_enable=1; cfg_serial_out = shift_reg[0] (combinational from the register).
  - Each cycle: shift right by one and increment bits_shifted.
  - Sample cfg_serial_return in the same cycle; if it is 1, set error (sticky). The chain was cleared, so the tail must read 0 for the first CHAIN_LENGTH shifts.
  - When the per-word count is exhausted: -> DONE if bits_shifted == CHAIN_LENGTH, else -> LOAD.
  - Surplus high bits of the final partial word are discarded and never driven.
- DONE:
  - done=1, busy=0, cfg_enable=0.
  - start=1 -> CLEAR (new load; done and error cleared); otherwise stay in DONE.
- busy = 1 in CLEAR, LOAD and SHIFT.
- start while busy is ignored and has no effect.
- word_valid outside LOAD is ignored; word_ready=0 there, so no word is consumed.
- Cycle cost per load (word_valid held high): CLEAR_CYCLES + NUM_WORDS + CHAIN_LENGTH cycles from the start edge to DONE entry.
- Reset mid-load:
  - Returns to IDLE immediately with outputs at reset values.
  - Chain contents are undefined and must be reloaded.
  - A partially consumed word is lost.
- The LOAD bubble is intentional: no shift occurs while word_ready=1, so cfg_enable and word_ready are never high together.

Test Plan:
- WORD_WIDTH=8, CHAIN_LENGTH=20, CLEAR_CYCLES=2; words 0xA5, 0x3C, 0x0F with word_valid always high; chain model returns 0 -> cfg_nreset low 2 cycles; 3 handshakes; cfg_serial_out sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1; DONE entered 25 cycles after start; done=1, error=0.
- Same config, word_valid deasserted for 5 cycles before the second word -> cfg_enable stays 0 for those cycles, the bit stream is unchanged, and total time is 30 cycles.
- Chain model whose tail is stuck at 1 -> error=1 from the first SHIFT cycle, still sticky in DONE; a new start clears it.
- Assert reset in the 3rd SHIFT cycle of word 2 -> next cycle (async) busy=0, cfg_enable=0, cfg_nreset=1, word_ready=0, state IDLE; a subsequent start performs a full clean load.
- Pulse start during SHIFT and again in DONE -> the first pulse has no effect; the second re-enters CLEAR with done=0.
- CHAIN_LENGTH=1, WORD_WIDTH=8, word 0xFE -> exactly one SHIFT cycle driving 0; DONE 2+1+1=4 cycles after start.

Source files
------------

// File: rtl/config_loader_if.sv
// Word handshake between a configuration source and the loader.
// The master presents words, the slave accepts them with word_ready.
interface config_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/config_loader.sv
// Serial configuration-chain driver: clears the chain, then shifts
// incoming words LSB-first while watching the tail for continuity.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  config_loader_if.slave word,
  output logic cfg_serial_out,
  output logic cfg_enable,
  output logic cfg_nreset,
  input  logic cfg_serial_return,
  output logic busy,
  output logic done,
  output logic error
);

  localparam int BW = $clog2(CHAIN_LENGTH + 1);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int KW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [BW-1:0]         bits_inc;
  logic [KW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         take;
  logic [CW-1:0]         clr_q, clr_d;
  logic [31:0]           rem;
  logic                  err_q, err_d;
  logic                  ready_q;
  logic                  en_q;
  logic                  nrst_q;
  logic                  busy_q;
  logic                  done_q;

  assign bits_inc = bits_q + BW'(1);

  // The last word may carry more bits than the chain still needs.
  always_comb begin
    rem  = 32'(CHAIN_LENGTH) - 32'(bits_q);
    take = KW'(WORD_WIDTH);
    if (rem < 32'(WORD_WIDTH))
      take = KW'(rem);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          err_d   = 1'b0;
          bits_d  = '0;
          clr_d   = CW'(CLEAR_CYCLES);
        end
      end
      S_CLEAR: begin
        if (clr_q == CW'(1))
          state_d = S_LOAD;
        else
          clr_d = clr_q - CW'(1);
      end
      S_LOAD: begin
        if (word.word_valid) begin
          shift_d = word.word_data;
          cnt_d   = take;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = shift_q >> 1;
        bits_d  = bits_inc;
        cnt_d   = cnt_q - KW'(1);
        if (cfg_serial_return)
          err_d = 1'b1;
        if (cnt_q == KW'(1)) begin
          if (bits_inc == BW'(CHAIN_LENGTH))
            state_d = S_DONE;
          else
            state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      nrst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      ready_q <= (state_d == S_LOAD);
      en_q    <= (state_d == S_SHIFT);
      nrst_q  <= (state_d != S_CLEAR);
      busy_q  <= (state_d == S_CLEAR) ||
                 (state_d == S_LOAD) ||
                 (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign word.word_ready = ready_q;
  assign cfg_serial_out  = en_q & shift_q[0];
  assign cfg_enable      = en_q;
  assign cfg_nreset      = nrst_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = err_q;

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: a 20-flop chain model and
// a 1-flop instance, with expected serial bits queued per load.
module tb_config_loader;

  logic clk;
  logic rst;
  logic start;
  logic stuck;
  logic sout, en, nrst, ret, busy, done, err;
  logic [19:0] chain;

  logic start2;
  logic sout2, en2, nrst2, ret2, busy2, done2, err2;
  logic ch2;

  int errors = 0;
  int checks = 0;
  int nr_low = 0;
  int en2_cnt = 0;

  logic q[$];
  logic q2[$];

  logic [7:0] words [3];
  logic [19:0] exp_stream;

  config_loader_if #(.WORD_WIDTH(8)) wif ();
  config_loader_if #(.WORD_WIDTH(8)) wif2 ();

  config_loader #(
    .WORD_WIDTH(8), .CHAIN_LENGTH(20), .CLEAR_CYCLES(2)
  ) dut (
    .clock(clk), .reset(rst), .start(start), .word(wif),
    .cfg_serial_out(sout), .cfg_enable(en), .cfg_nreset(nrst),
    .cfg_serial_return(ret), .busy(busy), .done(done), .error(err)
  );

  config_loader #(
    .WORD_WIDTH(8), .CHAIN_LENGTH(1), .CLEAR_CYCLES(2)
  ) dut2 (
    .clock(clk), .reset(rst), .start(start2), .word(wif2),
    .cfg_serial_out(sout2), .cfg_enable(en2), .cfg_nreset(nrst2),
    .cfg_serial_return(ret2), .busy(busy2), .done(done2), .error(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain models: head at the top, tail at bit 0.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) chain <= '0;
    else if (en) chain <= {sout, chain[19:1]};
  end
  assign ret = stuck ? 1'b1 : chain[0];

  always @(posedge clk or negedge nrst2) begin
    if (!nrst2) ch2 <= 1'b0;
    else if (en2) ch2 <= sout2;
  end
  assign ret2 = ch2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (!nrst) nr_low++;
      if (en) begin
        chk("enable_with_ready", 32'(wif.word_ready), 32'd0);
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_shift: got bit %0b expected none", sout);
        end else begin
          logic e;
          e = q.pop_front();
          if (sout !== e) begin
            errors++;
            $display("FAIL serial_bit: got %0b expected %0b", sout, e);
          end
        end
      end
      if (en2) begin
        en2_cnt++;
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL unexpected_shift2: got bit %0b expected none", sout2);
        end else begin
          logic e;
          e = q2.pop_front();
          if (sout2 !== e) begin
            errors++;
            $display("FAIL serial_bit2: got %0b expected %0b", sout2, e);
          end
        end
      end
    end
  end

  task automatic do_load(input int gap, input int exp_cyc,
                         input bit exp_err, input bit pulse_shift,
                         input bit abort);
    int cyc;
    int idx;
    int gapl;
    int w2;
    bit hs;
    bit first;
    bit errchk;
    bit seen;
    @(negedge clk);
    nr_low = 0;
    for (int i = 0; i < 20; i++) q.push_back(exp_stream[i]);
    start = 1'b1;
    wif.word_valid = 1'b0;
    cyc = -1; idx = 0; gapl = gap; w2 = 0;
    hs = 0; first = 0; errchk = 0; seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0)
        chk("start_enter", {busy, done, nrst, err}, 4'b1000);
      if (hs) idx++;
      hs = 0;
      if (errchk) begin
        chk("err_first_shift", 32'(err), 32'(exp_err));
        errchk = 0;
      end
      if (en && !first) begin
        first = 1;
        errchk = 1;
        if (pulse_shift) start = 1'b1;
      end
      if (en && idx == 2) w2++;
      if (abort && w2 == 3) begin
        rst = 1'b1;
        wif.word_valid = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_outputs",
            {busy, en, nrst, wif.word_ready, done, sout}, 6'b001000);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        return;
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (idx == 1 && gapl > 0 && wif.word_ready) begin
        wif.word_valid = 1'b0;
        gapl--;
        chk("gap_no_shift", 32'(en), 32'd0);
      end else begin
        wif.word_valid = (idx < 3);
        if (idx < 3) wif.word_data = words[idx];
      end
      hs = wif.word_valid && wif.word_ready;
    end
    wif.word_valid = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL load_timeout: got no done expected done");
    end
    chk("load_cycles", 32'(cyc), 32'(exp_cyc));
    chk("done_state", {done, busy, en, nrst}, 4'b1001);
    chk("error_final", 32'(err), 32'(exp_err));
    chk("handshakes", 32'(idx), 32'd3);
    chk("bits_left", 32'(q.size()), 32'd0);
    chk("nreset_low", 32'(nr_low), 32'd2);
    chk("chain_content", 32'(chain), 32'(exp_stream));
  endtask

  initial begin
    int cyc;
    bit seen;
    // 0x0F[3:0], 0x3C, 0xA5 concatenated: bit i is the i-th bit shifted
    exp_stream = 20'hF3CA5;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h0F;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    stuck = 1'b0;
    wif.word_valid = 1'b0;
    wif.word_data = '0;
    wif2.word_valid = 1'b0;
    wif2.word_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {wif.word_ready, sout, en, nrst, busy, done, err}, 7'b0001000);
    chk("reset_outputs2",
        {wif2.word_ready, sout2, en2, nrst2, busy2, done2, err2},
        7'b0001000);
    rst = 1'b0;

    do_load(0, 25, 1'b0, 1'b0, 1'b0);
    do_load(5, 30, 1'b0, 1'b0, 1'b0);
    stuck = 1'b1;
    do_load(0, 25, 1'b1, 1'b0, 1'b0);
    stuck = 1'b0;
    do_load(0, 25, 1'b0, 1'b0, 1'b0);
    do_load(0, 0, 1'b0, 1'b0, 1'b1);
    do_load(0, 25, 1'b0, 1'b0, 1'b0);
    do_load(0, 25, 1'b0, 1'b1, 1'b0);
    do_load(0, 25, 1'b0, 1'b0, 1'b0);

    // One-flop chain: only bit 0 of 0xFE is driven.
    @(negedge clk);
    q2.push_back(1'b0);
    en2_cnt = 0;
    start2 = 1'b1;
    wif2.word_valid = 1'b1;
    wif2.word_data = 8'hFE;
    cyc = -1;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        seen = 1;
        break;
      end
    end
    wif2.word_valid = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL load2_timeout: got no done expected done");
    end
    chk("load2_cycles", 32'(cyc), 32'd4);
    chk("load2_shifts", 32'(en2_cnt), 32'd1);
    chk("load2_done", {done2, busy2, err2}, 3'b100);
    chk("load2_bits_left", 32'(q2.size()), 32'd0);
    chk("load2_chain", 32'(ch2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
